piano_key_tracker: RTL and testbench

PIANO_KEY_TRACKER -- requirements
Module: piano_key_tracker

---
 rtl/piano_pkg.sv | 26 ++
 rtl/piano_key_tracker_if.sv | 30 +++
 rtl/note_evt_fifo.sv | 61 ++++++
 rtl/piano_key_tracker.sv | 187 ++++++++++++++++++
 tb/tb_piano_key_tracker.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/piano_pkg.sv
// Shared constants for the piano keyboard blocks.
// Holds the octave range and the note-id encoding (0 = no key, C..B = 1..12)
// used by the keyboard mapper, the octave block and the key tracker.
package piano_pkg;

    localparam int unsigned OCT_W      = 3;
    localparam int unsigned MAX_OCTAVE = 7;

    typedef logic [OCT_W-1:0] octave_t;

    // Note-id encoding, one semitone per id within an octave
    localparam logic [3:0] NOTE_NONE = 4'd0;
    localparam logic [3:0] NOTE_C    = 4'd1;
    localparam logic [3:0] NOTE_CS   = 4'd2;
    localparam logic [3:0] NOTE_D    = 4'd3;
    localparam logic [3:0] NOTE_DS   = 4'd4;
    localparam logic [3:0] NOTE_E    = 4'd5;
    localparam logic [3:0] NOTE_F    = 4'd6;
    localparam logic [3:0] NOTE_FS   = 4'd7;
    localparam logic [3:0] NOTE_G    = 4'd8;
    localparam logic [3:0] NOTE_GS   = 4'd9;
    localparam logic [3:0] NOTE_A    = 4'd10;
    localparam logic [3:0] NOTE_AS   = 4'd11;
    localparam logic [3:0] NOTE_B    = 4'd12;

endpackage

// File: rtl/piano_key_tracker_if.sv
// Key-event input stream and note-event output stream of the key tracker.
//   evt_valid/evt_ready/evt_note/evt_release : key press/release events in
//   out_valid/out_ready/out_note/out_octave/out_on : note-on/off events out
// master = event source / note consumer, slave = key tracker.
interface piano_key_tracker_if
    import piano_pkg::*;
#(
    parameter int unsigned NOTE_W = 4
);
    logic              evt_valid;
    logic [NOTE_W-1:0] evt_note;
    logic              evt_release;
    logic              evt_ready;

    logic              out_valid;
    logic              out_ready;
    logic [NOTE_W-1:0] out_note;
    octave_t           out_octave;
    logic              out_on;

    modport master (
        output evt_valid, evt_note, evt_release, out_ready,
        input  evt_ready, out_valid, out_note, out_octave, out_on
    );

    modport slave (
        input  evt_valid, evt_note, evt_release, out_ready,
        output evt_ready, out_valid, out_note, out_octave, out_on
    );
endinterface

// File: rtl/note_evt_fifo.sv
// Synchronous first-word-fall-through FIFO for note events.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO at the next edge (beats push/pop)
//   push_i/data_i : write side, ignored when full
//   pop_i/data_o  : read side, data_o shows the head word, pop ignored when empty
//   count_o       : current occupancy
module note_evt_fifo #(
    parameter  int unsigned WIDTH = 8,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic [PTR_W:0]   count_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB on each pointer separates full from empty when the indices match
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic             full, empty, do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push_i && !full && !flush_i;
    assign do_pop  = pop_i && !empty && !flush_i;
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: only words behind the write pointer are ever read
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= data_i;
    end
endmodule

// File: rtl/piano_key_tracker.sv
// Polyphonic piano key tracker.
// Accepts key press/release events, tracks which notes are held (with the
// octave each was pressed at), limits polyphony to MAX_POLY and emits
// note-on/note-off events through a FWFT FIFO.
//   CLK100MHZ, CPU_RESETN : clock, asynchronous active-low reset
//   octave       : octave sampled with each accepted press
//   all_off      : one-cycle panic, clears held keys and flushes the FIFO
//   key_status   : bit k-1 set while note k is held
//   active_count : number of held keys
//   poly_drop    : one-cycle pulse when a press is dropped at full polyphony
//   bus          : event input / note-event output streams
module piano_key_tracker
    import piano_pkg::*;
#(
    parameter  int unsigned NUM_KEYS   = 12,
    parameter  int unsigned MAX_POLY   = 4,
    parameter  int unsigned FIFO_DEPTH = 4,
    localparam int unsigned NOTE_W     = $clog2(NUM_KEYS + 1),
    localparam int unsigned CNT_W      = $clog2(MAX_POLY + 1)
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESETN,
    input  octave_t             octave,
    input  logic                all_off,
    output logic [NUM_KEYS-1:0] key_status,
    output logic [CNT_W-1:0]    active_count,
    output logic                poly_drop,
    piano_key_tracker_if.slave  bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned DAT_W = NOTE_W + 4;

    localparam logic [NOTE_W-1:0] NUM_KEYS_N   = NOTE_W'(NUM_KEYS);
    localparam logic [CNT_W-1:0]  MAX_POLY_N   = CNT_W'(MAX_POLY);
    localparam logic [OCC_W-1:0]  FIFO_DEPTH_N = OCC_W'(FIFO_DEPTH);

    // Output-stream FSM
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] HOLD   = 2'd1;
    localparam logic [1:0] STREAM = 2'd2;

    // Accepted event, decoded against the key state one cycle later
    logic              pend_q;
    logic [NOTE_W-1:0] pend_note_q;
    logic              pend_rel_q;
    octave_t           pend_oct_q;

    logic [NUM_KEYS-1:0] key_q, key_d;
    octave_t             oct_q [NUM_KEYS];
    octave_t             oct_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                drop_q, drop_d;
    logic [1:0]          state_q, state_d;

    logic              accept;
    logic              in_range, held;
    logic [NOTE_W-1:0] idx;
    logic              push, pop;
    logic [DAT_W-1:0]  push_data, fifo_data;
    logic [OCC_W-1:0]  fifo_count, occupancy;

    // The in-flight event counts against capacity so an accepted event always
    // finds room in the FIFO.
    assign occupancy     = fifo_count + OCC_W'(pend_q);
    assign bus.evt_ready = CPU_RESETN && !all_off && (occupancy < FIFO_DEPTH_N);
    assign accept        = bus.evt_valid && bus.evt_ready;

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            pend_q      <= 1'b0;
            pend_note_q <= '0;
            pend_rel_q  <= 1'b0;
            pend_oct_q  <= '0;
        end else begin
            pend_q <= accept;
            if (accept) begin
                pend_note_q <= bus.evt_note;
                pend_rel_q  <= bus.evt_release;
                pend_oct_q  <= octave;
            end
        end
    end

    assign in_range = (pend_note_q != '0) && (pend_note_q <= NUM_KEYS_N);
    assign idx      = pend_note_q - NOTE_W'(1);
    assign held     = in_range && key_q[idx];

    always_comb begin
        key_d     = key_q;
        oct_d     = oct_q;
        cnt_d     = cnt_q;
        drop_d    = 1'b0;
        push      = 1'b0;
        push_data = {pend_note_q, pend_oct_q, 1'b1};
        if (pend_q && in_range) begin
            if (!pend_rel_q) begin
                // Repeat press of a held key falls through with no effect
                if (!held) begin
                    if (cnt_q < MAX_POLY_N) begin
                        key_d[idx] = 1'b1;
                        oct_d[idx] = pend_oct_q;
                        cnt_d      = cnt_q + CNT_W'(1);
                        push       = 1'b1;
                    end else begin
                        drop_d = 1'b1;
                    end
                end
            end else if (held) begin
                key_d[idx] = 1'b0;
                cnt_d      = cnt_q - CNT_W'(1);
                push       = 1'b1;
                // Note-off reports the octave captured at press time
                push_data  = {pend_note_q, oct_q[idx], 1'b0};
            end
        end
        if (all_off) begin
            key_d  = '0;
            cnt_d  = '0;
            drop_d = 1'b0;
            push   = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            key_q  <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
            for (int k = 0; k < int'(NUM_KEYS); k++) oct_q[k] <= '0;
        end else begin
            key_q  <= key_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
            oct_q  <= oct_d;
        end
    end

    assign pop = bus.out_valid && bus.out_ready;

    note_evt_fifo #(
        .WIDTH (DAT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK100MHZ),
        .rst_ni  (CPU_RESETN),
        .flush_i (all_off),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (fifo_data),
        .count_o (fifo_count)
    );

    // FSM tracks FIFO occupancy so out_valid is a clean register output
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (push) state_d = HOLD;
            end
            HOLD, STREAM: begin
                if (pop) begin
                    state_d = (fifo_count == OCC_W'(1) && !push) ? IDLE : STREAM;
                end else begin
                    state_d = HOLD;
                end
            end
            default: state_d = IDLE;
        endcase
        if (all_off) state_d = IDLE;
    end

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) state_q <= IDLE;
        else             state_q <= state_d;
    end

    assign bus.out_valid  = (state_q != IDLE);
    assign bus.out_note   = fifo_data[DAT_W-1:4];
    assign bus.out_octave = fifo_data[3:1];
    assign bus.out_on     = fifo_data[0];

    assign key_status   = key_q;
    assign active_count = cnt_q;
    assign poly_drop    = drop_q;
endmodule

// File: tb/tb_piano_key_tracker.sv
// Directed bench for piano_key_tracker with a scoreboard of note events.
module tb_piano_key_tracker;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  oct_in;
    logic        all_off;
    logic [11:0] key_status;
    logic [2:0]  active_count;
    logic        poly_drop;

    int checks = 0;
    int errors = 0;
    int n_out  = 0;

    logic [7:0]  exp_q [$];
    logic [11:0] m_keys = '0;
    logic [2:0]  m_oct [12];
    int          m_cnt = 0;

    always #5 clk = ~clk;

    piano_key_tracker_if #(.NOTE_W(4)) bus ();

    piano_key_tracker #(
        .NUM_KEYS   (12),
        .MAX_POLY   (4),
        .FIFO_DEPTH (4)
    ) dut (
        .CLK100MHZ    (clk),
        .CPU_RESETN   (rst_n),
        .octave       (oct_in),
        .all_off      (all_off),
        .key_status   (key_status),
        .active_count (active_count),
        .poly_drop    (poly_drop),
        .bus          (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one accepted event
    task automatic model(input logic [3:0] n, input bit rel, input logic [2:0] oct);
        int i;
        if (n == 4'd0 || n > 4'd12) return;
        i = int'(n) - 1;
        if (!rel) begin
            if (!m_keys[i] && m_cnt < 4) begin
                m_keys[i] = 1'b1;
                m_oct[i]  = oct;
                m_cnt++;
                exp_q.push_back({n, oct, 1'b1});
            end
        end else if (m_keys[i]) begin
            m_keys[i] = 1'b0;
            m_cnt--;
            exp_q.push_back({n, m_oct[i], 1'b0});
        end
    endtask

    // Present one event and hold it until accepted (bounded)
    task automatic send(input logic [3:0] n, input bit rel, input logic [2:0] oct,
                        input bit track);
        bit ok = 1'b0;
        bus.evt_valid   = 1'b1;
        bus.evt_note    = n;
        bus.evt_release = rel;
        oct_in          = oct;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.evt_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        bus.evt_valid = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: note %0d evt_ready observed 0 expected 1", n);
        end else if (track) begin
            model(n, rel, oct);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_keys"}, 32'(key_status), 32'(m_keys));
        chk({tag, "_count"}, 32'(active_count), 32'(m_cnt));
    endtask

    task automatic drain(input string tag);
        bus.out_ready = 1'b1;
        repeat (10) step();
        chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    endtask

    // Output monitor: a pop happens at the next edge when both are high here
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL out_event: observed note %0d oct %0d on %0d expected no event",
                       bus.out_note, bus.out_octave, bus.out_on);
            end else begin
                chk("out_event", 32'({bus.out_note, bus.out_octave, bus.out_on}),
                    32'(exp_q.pop_front()));
                n_out++;
            end
        end
    end

    initial begin
        #2_000_000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end

    initial begin
        int base;
        rst_n           = 1'b0;
        oct_in          = '0;
        all_off         = 1'b0;
        bus.evt_valid   = 1'b0;
        bus.evt_note    = '0;
        bus.evt_release = 1'b0;
        bus.out_ready   = 1'b0;
        for (int k = 0; k < 12; k++) m_oct[k] = '0;

        // Reset state
        #12;
        chk("rst_evt_ready", 32'(bus.evt_ready), 32'd0);
        chk("rst_keys", 32'(key_status), 32'd0);
        chk("rst_count", 32'(active_count), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_poly_drop", 32'(poly_drop), 32'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_evt_ready", 32'(bus.evt_ready), 32'd1);
        step();

        // Single press: one-cycle decode then first-word fall-through
        bus.out_ready = 1'b1;
        send(4'd1, 1'b0, 3'd3, 1'b1);
        chk("lat_keys_pre", 32'(key_status), 32'd0);
        chk("lat_valid_pre", 32'(bus.out_valid), 32'd0);
        step();
        chk("press1_keys", 32'(key_status), 32'h001);
        chk("press1_count", 32'(active_count), 32'd1);
        chk("press1_valid", 32'(bus.out_valid), 32'd1);
        chk("press1_event", 32'({bus.out_note, bus.out_octave, bus.out_on}),
            32'({4'd1, 3'd3, 1'b1}));
        send(4'd1, 1'b1, 3'd0, 1'b1);
        drain("press1");

        // Note-off carries the press octave, not the current one
        send(4'd5, 1'b0, 3'd2, 1'b1);
        oct_in = 3'd6;
        step();
        send(4'd5, 1'b1, 3'd6, 1'b1);
        drain("octave_hold");
        check_state("octave_hold");

        // Polyphony limit
        base = n_out;
        for (int n = 1; n <= 4; n++) send(4'(n), 1'b0, 3'd4, 1'b1);
        send(4'd5, 1'b0, 3'd4, 1'b1);
        step();
        chk("poly_drop_pulse", 32'(poly_drop), 32'd1);
        step();
        chk("poly_drop_clear", 32'(poly_drop), 32'd0);
        chk("poly_keys", 32'(key_status), 32'h00F);
        check_state("poly");
        drain("poly");
        chk("poly_note_ons", 32'(n_out - base), 32'd4);
        for (int n = 1; n <= 4; n++) send(4'(n), 1'b1, 3'd0, 1'b1);
        drain("poly_release");

        // Back-pressure: FIFO plus in-flight slot fill after four acceptances
        bus.out_ready = 1'b0;
        send(4'd6, 1'b0, 3'd1, 1'b1);
        send(4'd7, 1'b0, 3'd2, 1'b1);
        send(4'd8, 1'b0, 3'd3, 1'b1);
        chk("bp_ready_3", 32'(bus.evt_ready), 32'd1);
        send(4'd9, 1'b0, 3'd4, 1'b1);
        chk("bp_ready_4", 32'(bus.evt_ready), 32'd0);
        fork
            send(4'd10, 1'b0, 3'd5, 1'b1);
            begin
                repeat (3) step();
                chk("bp_ready_full", 32'(bus.evt_ready), 32'd0);
                bus.out_ready = 1'b1;
            end
        join
        drain("bp");
        check_state("bp");
        for (int n = 6; n <= 9; n++) send(4'(n), 1'b1, 3'd0, 1'b1);
        drain("bp_release");

        // Repeat press, release of idle key, out-of-range and zero ids
        send(4'd7, 1'b0, 3'd1, 1'b1);
        send(4'd7, 1'b0, 3'd5, 1'b1);
        send(4'd9, 1'b1, 3'd0, 1'b1);
        send(4'd13, 1'b0, 3'd2, 1'b1);
        send(4'd0, 1'b0, 3'd2, 1'b1);
        drain("ignore");
        chk("ignore_keys", 32'(key_status), 32'h040);
        check_state("ignore");
        send(4'd7, 1'b1, 3'd0, 1'b1);
        drain("ignore_release");

        // all_off wins over a concurrent press and flushes queued events
        send(4'd3, 1'b0, 3'd1, 1'b1);
        drain("panic_pre");
        bus.out_ready = 1'b0;
        send(4'd4, 1'b0, 3'd2, 1'b1);
        send(4'd5, 1'b0, 3'd3, 1'b1);
        step();
        check_state("panic_held");
        chk("panic_queued", 32'(bus.out_valid), 32'd1);
        all_off         = 1'b1;
        bus.evt_valid   = 1'b1;
        bus.evt_note    = 4'd2;
        bus.evt_release = 1'b0;
        #1;
        chk("panic_evt_ready", 32'(bus.evt_ready), 32'd0);
        @(posedge clk);
        #1;
        all_off       = 1'b0;
        bus.evt_valid = 1'b0;
        m_keys        = '0;
        m_cnt         = 0;
        exp_q.delete();
        chk("panic_keys", 32'(key_status), 32'd0);
        chk("panic_count", 32'(active_count), 32'd0);
        chk("panic_out_valid", 32'(bus.out_valid), 32'd0);
        repeat (3) step();
        chk("panic_press_dropped", 32'(key_status), 32'd0);
        chk("panic_still_empty", 32'(bus.out_valid), 32'd0);

        // Reset right after a handshake discards the event
        bus.out_ready = 1'b1;
        send(4'd8, 1'b0, 3'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_evt_ready", 32'(bus.evt_ready), 32'd0);
        step();
        rst_n = 1'b1;
        repeat (3) step();
        chk("midrst_keys", 32'(key_status), 32'd0);
        chk("midrst_count", 32'(active_count), 32'd0);
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_evt_ready_after", 32'(bus.evt_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
